// File: rtl/microcode_sequencer.sv
// Microcode sequencer: accepts one decoded instruction, walks the command lookup
// step by step and streams micro-ops to the read stage under valid/ready.
module microcode_sequencer #(
  parameter logic [6:0] CMD_NULL = 7'd0,
  parameter logic [5:0] MAX_STEP = 6'd63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exc_init,
  input  logic       dec_ready,
  input  logic [6:0] dec_cmd,
  input  logic [3:0] dec_cmdex,
  output logic       dec_accept,
  output logic [6:0] mc_cmd,
  output logic [5:0] mc_step,
  output logic [3:0] mc_cmdex_last,
  input  logic [6:0] mc_cmd_next,
  input  logic [6:0] mc_cmd_current,
  input  logic [3:0] mc_cmdex_current,
  output logic       out_valid,
  output logic [6:0] out_cmd,
  output logic [3:0] out_cmdex,
  output logic [5:0] out_step,
  input  logic       out_ready,
  output logic       instr_done,
  output logic       mc_overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state_reg;
  logic       can_issue;
  logic       in_run;
  logic       finish;
  logic       run_issue;

  assign can_issue  = !out_valid || out_ready;
  assign in_run     = (state_reg == RUN);
  // Completion is decided on the lookup's answer alone; it never waits for the read stage.
  assign finish     = in_run && !exc_init &&
                      ((mc_cmd_next == CMD_NULL) || (mc_step == MAX_STEP));
  assign run_issue  = in_run && !exc_init && !finish && can_issue;
  assign dec_accept = !in_run && dec_ready && can_issue && !exc_init;
  assign instr_done = finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mc_cmd        <= '0;
      mc_step       <= '0;
      mc_cmdex_last <= '0;
      out_valid     <= 1'b0;
      out_cmd       <= '0;
      out_cmdex     <= '0;
      out_step      <= '0;
      mc_overflow   <= 1'b0;
    end else if (exc_init) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      mc_step   <= '0;
    end else if (dec_accept) begin
      out_cmd       <= dec_cmd;
      out_cmdex     <= dec_cmdex;
      out_step      <= '0;
      out_valid     <= 1'b1;
      mc_cmd        <= dec_cmd;
      mc_cmdex_last <= dec_cmdex;
      mc_step       <= 6'd1;
      state_reg     <= RUN;
    end else if (finish) begin
      state_reg <= IDLE;
      mc_step   <= '0;
      // A non-null next command here means the step limit was reached first.
      if (mc_cmd_next != CMD_NULL) begin
        mc_overflow <= 1'b1;
      end
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (run_issue) begin
      out_cmd       <= mc_cmd_current;
      out_cmdex     <= mc_cmdex_current;
      out_step      <= mc_step;
      out_valid     <= 1'b1;
      mc_cmd        <= mc_cmd_next;
      mc_cmdex_last <= mc_cmdex_current;
      mc_step       <= mc_step + 6'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a modelled command lookup feeds the DUT,
// expected micro-op streams are queued on accept and checked on each handshake.
module tb_microcode_sequencer;

  typedef struct packed {
    logic [6:0] cmd;
    logic [3:0] cmdex;
    logic [5:0] step;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       exc_init;
  logic       dec_ready;
  logic [6:0] dec_cmd;
  logic [3:0] dec_cmdex;
  logic       dec_accept;
  logic [6:0] mc_cmd;
  logic [5:0] mc_step;
  logic [3:0] mc_cmdex_last;
  logic [6:0] mc_cmd_next;
  logic [6:0] mc_cmd_current;
  logic [3:0] mc_cmdex_current;
  logic       out_valid;
  logic [6:0] out_cmd;
  logic [3:0] out_cmdex;
  logic [5:0] out_step;
  logic       out_ready;
  logic       instr_done;
  logic       mc_overflow;

  int dec_len;
  int run_len = 1;
  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int acc_cyc[$];
  int done_cyc[$];
  op_t op_q[$];
  bit done_q[$];
  bit ovf_exp = 1'b0;
  bit prev_exc = 1'b0;
  bit prev_acc = 1'b0;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .exc_init(exc_init),
    .dec_ready(dec_ready), .dec_cmd(dec_cmd), .dec_cmdex(dec_cmdex), .dec_accept(dec_accept),
    .mc_cmd(mc_cmd), .mc_step(mc_step), .mc_cmdex_last(mc_cmdex_last),
    .mc_cmd_next(mc_cmd_next), .mc_cmd_current(mc_cmd_current), .mc_cmdex_current(mc_cmdex_current),
    .out_valid(out_valid), .out_cmd(out_cmd), .out_cmdex(out_cmdex), .out_step(out_step),
    .out_ready(out_ready), .instr_done(instr_done), .mc_overflow(mc_overflow)
  );

  // Environment lookup: instruction of run_len micro-ops; each step bumps cmdex by one
  // and the following command is {1, low six bits + 1}.
  assign mc_cmd_current   = mc_cmd;
  assign mc_cmdex_current = mc_cmdex_last + 4'd1;
  assign mc_cmd_next      = (int'(mc_step) < run_len) ? {1'b1, mc_cmd[5:0] + 6'd1} : 7'd0;

  always @(posedge clk) if (dec_accept) run_len <= dec_len;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      op_q.delete();
      done_q.delete();
      ovf_exp  = 1'b0;
      prev_exc = 1'b0;
      prev_acc = 1'b0;
    end else begin
      check_eq("overflow_flag", int'(mc_overflow), int'(ovf_exp));
      if (prev_exc) begin
        check_eq("flush_out_valid", int'(out_valid), 0);
        check_eq("flush_mc_step", int'(mc_step), 0);
      end
      if (prev_acc) check_eq("accept_latency", int'(out_valid), 1);
      if (exc_init) begin
        check_eq("exc_accept", int'(dec_accept), 0);
        check_eq("exc_done", int'(instr_done), 0);
      end
      if (instr_done) check_eq("done_accept", int'(dec_accept), 0);
      if (out_valid && out_ready) begin
        if (op_q.size() == 0) begin
          check_eq("unexpected_op", int'({out_cmd, out_cmdex, out_step}), -1);
        end else begin
          op_t e;
          e = op_q.pop_front();
          $display("op cycle %0d: cmd=%h cmdex=%h step=%0d (want %h %h %0d)",
                   cyc, out_cmd, out_cmdex, out_step, e.cmd, e.cmdex, e.step);
          check_eq("op_cmd", int'(out_cmd), int'(e.cmd));
          check_eq("op_cmdex", int'(out_cmdex), int'(e.cmdex));
          check_eq("op_step", int'(out_step), int'(e.step));
        end
      end
      if (instr_done) begin
        done_cyc.push_back(cyc);
        if (done_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          bit f;
          f = done_q.pop_front();
          check_eq("ops_left_at_done", op_q.size(), (out_valid && !out_ready) ? 1 : 0);
          if (f) ovf_exp = 1'b1;
        end
      end
      if (exc_init) begin
        op_q.delete();
        done_q.delete();
      end
      if (dec_accept) begin
        int nops;
        nops = (dec_len < 63) ? dec_len : 63;
        for (int k = 0; k < nops; k++) begin
          op_t e;
          e.step  = 6'(k);
          e.cmdex = 4'(int'(dec_cmdex) + k);
          e.cmd   = (k <= 1) ? dec_cmd : {1'b1, 6'(int'(dec_cmd[5:0]) + k - 1)};
          op_q.push_back(e);
        end
        done_q.push_back(dec_len >= 64);
        acc_cyc.push_back(cyc);
        acc_cnt++;
      end
      prev_exc = exc_init;
      prev_acc = dec_accept;
    end
  end

  task automatic present(input logic [6:0] c, input logic [3:0] x, input int len);
    dec_cmd = c; dec_cmdex = x; dec_len = len; dec_ready = 1'b1;
  endtask

  task automatic wait_accept();
    int base;
    bit got;
    base = acc_cnt;
    got  = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != base) got = 1'b1;
    end
    if (!got) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    dec_ready = 1'b0; exc_init = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(posedge clk); #1;
      if (op_q.size() == 0 && done_q.size() == 0 && !out_valid) idle = 1'b1;
    end
    if (!idle) check_eq("drain_timeout", op_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d, seen, n_instr;
    bit hit;
    int fixed_len [4];
    rst_n = 1'b0; exc_init = 1'b0; dec_ready = 1'b0; dec_cmd = '0; dec_cmdex = '0;
    dec_len = 1; out_ready = 1'b0;
    #1;
    check_eq("reset_out_valid", int'(out_valid), 0);
    check_eq("reset_mc_step", int'(mc_step), 0);
    check_eq("reset_overflow", int'(mc_overflow), 0);
    check_eq("reset_done", int'(instr_done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back 3-op and 1-op instructions with no backpressure.
    out_ready = 1'b1;
    b = acc_cyc.size(); d = done_cyc.size();
    present(7'h10, 4'h0, 3);
    wait_accept();
    present(7'h22, 4'h5, 1);
    wait_accept();
    dec_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (acc_cyc.size() >= b + 2 && done_cyc.size() >= d + 2) begin
      check_eq("accept_spacing", acc_cyc[b+1] - acc_cyc[b], 4);
      check_eq("done_3op", done_cyc[d] - acc_cyc[b], 3);
      check_eq("done_1op", done_cyc[d+1] - acc_cyc[b+1], 1);
    end else begin
      check_eq("timing_events", done_cyc.size() - d, 2);
    end

    // Backpressure at step 1 for three cycles.
    present(7'h10, 4'h0, 4);
    wait_accept();
    dec_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("stall_out_step", int'(out_step), 1);
      check_eq("stall_mc_step", int'(mc_step), 2);
      check_eq("stall_out_valid", int'(out_valid), 1);
    end
    drain();

    // Flush while step 2 is on the output and a new instruction is waiting.
    present(7'h30, 4'h3, 10);
    wait_accept();
    dec_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_exc_step", int'(out_step), 2);
    exc_init = 1'b1;
    present(7'h41, 4'h1, 2);
    #1 check_eq("exc_cycle_accept", int'(dec_accept), 0);
    @(posedge clk); #1;
    exc_init = 1'b0;
    wait_accept();
    drain();

    // Asynchronous reset in the middle of an instruction.
    present(7'h50, 4'h2, 10);
    wait_accept();
    dec_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mc_step == 6'd3) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("mid_run_step", int'(mc_step), 3);
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_mc_step", int'(mc_step), 0);
    check_eq("rst_mc_cmd", int'(mc_cmd), 0);
    check_eq("rst_out_bundle", int'({out_cmd, out_cmdex, out_step}), 0);
    check_eq("rst_instr_done", int'(instr_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic; the first instructions probe the step limit.
    fixed_len[0] = 100; fixed_len[1] = 63; fixed_len[2] = 64; fixed_len[3] = 2;
    seen = acc_cnt; n_instr = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (acc_cnt != seen) begin seen = acc_cnt; dec_ready = 1'b0; end
      out_ready = ($urandom_range(0, 3) != 0);
      exc_init  = (c > 700) && ($urandom_range(0, 39) == 0);
      if (!dec_ready && $urandom_range(0, 2) == 0) begin
        present(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
                (n_instr < 4) ? fixed_len[n_instr] : int'($urandom_range(1, 9)));
        n_instr++;
      end
    end
    drain();
    check_eq("overflow_sticky_end", int'(mc_overflow), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
